mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_BYTES, 4096, byte capacity of the downstream memory; legal addresses are 0..MEM_BYTES-1.
REQ-002 Parameter: FAIR_LIMIT, 2, consecutive data grants allowed while a fetch waits.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 if_req  in  1  fetch request, held until granted.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_gnt  out  1  fetch request accepted this cycle.
REQ-008 if_rvalid  out  1  fetch word valid this cycle.
REQ-009 if_rdata  out  32  fetched instruction word.
REQ-010 d_req  in  1  data request, held with its fields until granted.
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_funct3  in  3  RV32I load/store funct3.
REQ-013 d_addr  in  32  data byte address.
REQ-014 d_wdata  in  32  store data, low bytes significant.
REQ-015 d_gnt  out  1  data request accepted this cycle.
REQ-016 d_done  out  1  data access complete this cycle, load or store.
REQ-017 d_rdata  out  32  load result, already extended.
REQ-018 d_err  out  1  qualifies d_done: illegal funct3 or out-of-range access.
REQ-019 mem_read, mem_write  out  1 each  memory strobes.
REQ-020 mem_mode  out  3  memory mode: 000 W, 001 HU, 010 BU, 011 H signed, 100 B signed.
REQ-021 mem_addr, mem_wdata  out  32 each  memory address and store data.
REQ-022 mem_rdata  in  32  memory read data; registered in memory, valid the cycle after the address is presented.

Function
REQ-023 FSM states: IDLE, ISSUE, RESP; grants are possible only in IDLE and RESP.
REQ-024 Grants: if_gnt/d_gnt combinational from the requests and state; at most one per cycle.
REQ-025 Arbitration: data wins, except fetch wins once FAIR_LIMIT consecutive data grants have occurred while if_req was high.
REQ-026 Fairness counter: cleared on any fetch grant or when if_req is low.
REQ-027 Accepted request in cycle N: mem_* registered at the edge ending N, driven for all of cycle N+1 (ISSUE).
REQ-028 Response: if_rvalid or d_done asserted in cycle N+2 (RESP) for exactly one cycle.
REQ-029 Read data: if_rdata/d_rdata driven combinationally from mem_rdata in RESP; 0 otherwise.
REQ-030 Throughput: a grant in RESP goes directly to ISSUE, giving one access per 2 cycles; no grant in RESP -> IDLE.
REQ-031 Fetch: always mem_mode 000, mem_read=1.
REQ-032 Load mapping (funct3->mode): 000->100, 001->011, 010->000, 100->010, 101->001.
REQ-033 Store mapping: 000->010, 001->001, 010->000; mem_write=1.
REQ-034 Illegal funct3 gives d_err: loads 011/110/111, stores 011..111.
REQ-035 Range error: addr + size - 1 > MEM_BYTES-1 (size 1/2/4, 33-bit compare, no wrap) gives d_err; applies to fetches too.
REQ-036 On any error, mem_read and mem_write stay 0 in ISSUE.
REQ-037 Fetch error reporting: no error port; if_rvalid is asserted with if_rdata = 32'h0000_0013 (NOP).
REQ-038 Outside ISSUE: mem_read=mem_write=0; mem_addr, mem_mode and mem_wdata hold their last values.
REQ-039 Misaligned but in-range accesses are legal and passed through unchanged.

Reset
REQ-040 While rst is high: state IDLE, fairness counter 0, all mem_* outputs 0, no grants, rvalid/done/err 0.
REQ-041 Reset mid-operation: the outstanding access is abandoned with no response; an ISSUE-cycle write is cancelled if rst rises before the clock edge.
REQ-042 First grant possible in the first cycle after rst falls.

Structure
REQ-043 Package mem_arb_pkg holds the state enum, the five mem_mode constants, the funct3 constants and the NOP constant.
REQ-044 One sub-module, ls_mode_decode, is combinational: (we, funct3, addr) -> (mode, size, err).

Verification
REQ-045 Single fetch: if_req, if_addr=0x10, mem word 0xDEADBEEF -> if_gnt at N, mem_read/mode 000 at N+1, if_rvalid with 0xDEADBEEF at N+2.
REQ-046 Load signed byte: funct3 000, mem byte 0x80 -> mem_mode 100, d_rdata 0xFFFFFF80. LHU on 0x8001 -> mode 001, d_rdata 0x00008001.
REQ-047 SH 0x1234ABCD to 0x20 then LW 0x20 (old word 0) -> mem_write mode 001; load returns 0x0000ABCD.
REQ-048 Contention: d_req and if_req high continuously -> grant order D,D,I,D,D,I, one grant per 2 cycles.
REQ-049 Errors: LW at 0xFFE (MEM_BYTES=4096), or funct3 011 -> d_done+d_err, no mem strobe. Fetch at 0x1000 -> if_rdata 0x00000013.
REQ-050 rst pulsed during ISSUE of a store -> no d_done, target byte unchanged, IDLE after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Memory modes, RV32I load/store funct3 codes, FSM states and the range check.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_t;

    localparam logic [2:0] MODE_W  = 3'b000;
    localparam logic [2:0] MODE_HU = 3'b001;
    localparam logic [2:0] MODE_BU = 3'b010;
    localparam logic [2:0] MODE_H  = 3'b011;
    localparam logic [2:0] MODE_B  = 3'b100;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // 33-bit end-address compare so accesses near 2^32 cannot wrap into range.
    function automatic logic range_err(input logic [31:0] addr,
                                       input logic [2:0]  size,
                                       input logic [32:0] limit);
        logic [32:0] last;
        last = {1'b0, addr} + {30'd0, size} - 33'd1;
        return last > (limit - 33'd1);
    endfunction

endpackage

// File: rtl/ls_mode_decode.sv
// Combinational load/store decode: funct3 to memory mode and access size,
// flagging illegal encodings and accesses that run past the end of memory.
module ls_mode_decode
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    output logic [2:0]  mode,
    output logic [2:0]  size,
    output logic        err
);

    logic f3_err;

    always_comb begin
        mode   = MODE_W;
        size   = 3'd4;
        f3_err = 1'b0;
        if (we) begin
            // Stores never sign-extend, so only the unsigned modes appear.
            case (funct3)
                F3_B:    begin mode = MODE_BU; size = 3'd1; end
                F3_H:    begin mode = MODE_HU; size = 3'd2; end
                F3_W:    begin mode = MODE_W;  size = 3'd4; end
                default: f3_err = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_B:    begin mode = MODE_B;  size = 3'd1; end
                F3_H:    begin mode = MODE_H;  size = 3'd2; end
                F3_W:    begin mode = MODE_W;  size = 3'd4; end
                F3_BU:   begin mode = MODE_BU; size = 3'd1; end
                F3_HU:   begin mode = MODE_HU; size = 3'd2; end
                default: f3_err = 1'b1;
            endcase
        end
        err = f3_err | range_err(addr, size, 33'(MEM_BYTES));
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single registered
// memory: one access per two cycles, data priority with bounded fetch starvation.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_BYTES  = 4096,
    parameter int unsigned FAIR_LIMIT = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        d_err,

    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_mode,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = (FAIR_LIMIT < 1) ? 1 : $clog2(FAIR_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FAIR_LIMIT);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] fair_cnt;
    logic             grant_ok;
    logic             fetch_wins;
    logic             f_err;
    logic [2:0]       d_mode;
    logic [2:0]       d_size;
    logic             d_dec_err;
    logic             own_fetch_p1;
    logic             acc_err_p1;
    logic             acc_we_p1;
    logic             resp;

    ls_mode_decode #(
        .MEM_BYTES (MEM_BYTES)
    ) u_decode (
        .we     (d_we),
        .funct3 (d_funct3),
        .addr   (d_addr),
        .mode   (d_mode),
        .size   (d_size),
        .err    (d_dec_err)
    );

    assign f_err = range_err(if_addr, 3'd4, 33'(MEM_BYTES));

    // Grants are held off while rst is high so nothing is accepted in reset.
    assign grant_ok   = ((state == ST_IDLE) || (state == ST_RESP)) && !rst;
    assign fetch_wins = if_req && (!d_req || (fair_cnt >= CNT_MAX));
    assign if_gnt     = grant_ok && fetch_wins;
    assign d_gnt      = grant_ok && d_req && !fetch_wins;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (if_gnt || d_gnt) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_RESP;
            ST_RESP:  state_nxt = (if_gnt || d_gnt) ? ST_ISSUE : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            fair_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (if_gnt || !if_req)
                fair_cnt <= '0;
            else if (d_gnt && (fair_cnt < CNT_MAX))
                fair_cnt <= fair_cnt + 1'b1;
        end
    end

    // ---- grant -> ISSUE: capture the winning request onto the memory port ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_mode     <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            own_fetch_p1 <= 1'b0;
            acc_err_p1   <= 1'b0;
            acc_we_p1    <= 1'b0;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (if_gnt) begin
                mem_addr     <= if_addr;
                mem_mode     <= MODE_W;
                mem_read     <= !f_err;
                own_fetch_p1 <= 1'b1;
                acc_err_p1   <= f_err;
                acc_we_p1    <= 1'b0;
            end else if (d_gnt) begin
                mem_addr     <= d_addr;
                mem_mode     <= d_mode;
                mem_wdata    <= d_wdata;
                mem_read     <= !d_we && !d_dec_err;
                mem_write    <= d_we && !d_dec_err;
                own_fetch_p1 <= 1'b0;
                acc_err_p1   <= d_dec_err;
                acc_we_p1    <= d_we;
            end
        end
    end

    // ---- RESP: memory data arrives one cycle after ISSUE ----
    assign resp      = (state == ST_RESP);
    assign if_rvalid = resp && own_fetch_p1;
    assign if_rdata  = !if_rvalid ? 32'd0 : (acc_err_p1 ? NOP_INSN : mem_rdata);
    assign d_done    = resp && !own_fetch_p1;
    assign d_err     = d_done && acc_err_p1;
    assign d_rdata   = (d_done && !acc_err_p1 && !acc_we_p1) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-addressed registered memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_done, d_err;
    logic [31:0] d_rdata;
    logic        mem_read, mem_write;
    logic [2:0]  mem_mode;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic        poke_en = 1'b0;
    logic [11:0] poke_addr = '0;
    logic [31:0] poke_data = '0;
    logic [7:0]  mem [0:4095];

    logic        o_gnt, o_rd, o_wr, o_vld, o_err;
    logic [2:0]  o_mode;
    logic [31:0] o_addr, o_wdata, o_rdata;
    int          o_wait;

    mem_arbiter #(.MEM_BYTES(4096), .FAIR_LIMIT(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .d_err(d_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_mode(mem_mode),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [11:0] a, input logic [2:0] m);
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[a]; b1 = mem[a + 12'd1]; b2 = mem[a + 12'd2]; b3 = mem[a + 12'd3];
        case (m)
            3'b000:  return {b3, b2, b1, b0};
            3'b001:  return {16'd0, b1, b0};
            3'b010:  return {24'd0, b0};
            3'b011:  return {{16{b1[7]}}, b1, b0};
            3'b100:  return {{24{b0[7]}}, b0};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_addr]         <= poke_data[7:0];
            mem[poke_addr + 12'd1] <= poke_data[15:8];
            mem[poke_addr + 12'd2] <= poke_data[23:16];
            mem[poke_addr + 12'd3] <= poke_data[31:24];
        end else if (mem_write) begin
            mem[mem_addr[11:0]] <= mem_wdata[7:0];
            if (mem_mode != 3'b010) mem[mem_addr[11:0] + 12'd1] <= mem_wdata[15:8];
            if (mem_mode == 3'b000) begin
                mem[mem_addr[11:0] + 12'd2] <= mem_wdata[23:16];
                mem[mem_addr[11:0] + 12'd3] <= mem_wdata[31:24];
            end
        end
        if (mem_read) mem_rdata <= mem_rd(mem_addr[11:0], mem_mode);
    end

    task automatic poke(input logic [11:0] a, input logic [31:0] v);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = v;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic data_txn(input logic we, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
        #1;
        o_wait = 0;
        while (!d_gnt && o_wait < 20) begin
            @(negedge clk); #1; o_wait++;
        end
        o_gnt = d_gnt;
        @(negedge clk);
        d_req = 1'b0;
        #1;
        o_rd = mem_read; o_wr = mem_write; o_mode = mem_mode;
        o_addr = mem_addr; o_wdata = mem_wdata;
        @(negedge clk); #1;
        o_vld = d_done; o_err = d_err; o_rdata = d_rdata;
    endtask

    task automatic fetch_txn(input logic [31:0] a);
        @(negedge clk);
        if_req = 1'b1; if_addr = a;
        #1;
        o_wait = 0;
        while (!if_gnt && o_wait < 20) begin
            @(negedge clk); #1; o_wait++;
        end
        o_gnt = if_gnt;
        @(negedge clk);
        if_req = 1'b0;
        #1;
        o_rd = mem_read; o_wr = mem_write; o_mode = mem_mode; o_addr = mem_addr;
        o_vld = if_rvalid;
        @(negedge clk); #1;
        o_err = if_rvalid; o_rdata = if_rdata;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0;
        d_funct3 = 3'b010; d_addr = 32'h0; d_wdata = 32'h0;
        poke(12'h010, 32'hDEADBEEF);
        poke(12'h040, 32'h80010080);
        poke(12'h044, 32'h00000000);
        poke(12'h020, 32'h00000000);
        poke(12'h030, 32'h000000AA);
        poke(12'hFFC, 32'h11223344);
        poke(12'h000, 32'h00000000);
        #1;
        checks++;
        if ({if_gnt, d_gnt, mem_read, mem_write, if_rvalid, d_done, d_err} !== 7'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {if_gnt, d_gnt, mem_read, mem_write, if_rvalid, d_done, d_err});
        end
        checks++;
        if ({mem_mode, mem_addr, mem_wdata} !== 67'd0) begin
            errors++;
            $display("FAIL reset_mem: mode %h addr %h wdata %h required all 0",
                     mem_mode, mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst = 1'b0; d_req = 1'b0;
        #1;
        checks++;
        if (if_gnt !== 1'b1) begin
            errors++;
            $display("FAIL first_grant: if_gnt %b required 1", if_gnt);
        end
        if_req = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (mem_read !== 1'b0) begin
            errors++;
            $display("FAIL withdrawn_req: mem_read %b required 0", mem_read);
        end
    endtask

    task automatic test_fetch();
        fetch_txn(32'h10);
        checks++;
        if (o_gnt !== 1'b1 || o_wait != 0) begin
            errors++;
            $display("FAIL fetch_gnt: gnt %b wait %0d required 1 and 0", o_gnt, o_wait);
        end
        checks++;
        if ({o_rd, o_wr, o_mode, o_addr, o_vld} !== {1'b1, 1'b0, 3'b000, 32'h10, 1'b0}) begin
            errors++;
            $display("FAIL fetch_issue: rd %b wr %b mode %h addr %h vld %b required 1 0 0 10 0",
                     o_rd, o_wr, o_mode, o_addr, o_vld);
        end
        checks++;
        if (o_err !== 1'b1 || o_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL fetch_resp: rvalid %b rdata %h required 1 deadbeef", o_err, o_rdata);
        end
        @(negedge clk); #1;
        checks++;
        if (if_rvalid !== 1'b0 || if_rdata !== 32'd0) begin
            errors++;
            $display("FAIL fetch_one_cycle: rvalid %b rdata %h required 0 0", if_rvalid, if_rdata);
        end
    endtask

    task automatic test_loads();
        data_txn(1'b0, 3'b000, 32'h40, 32'h0);
        checks++;
        if ({o_gnt, o_rd, o_mode, o_vld, o_err, o_rdata} !== {1'b1, 1'b1, 3'b100, 1'b1, 1'b0, 32'hFFFFFF80}) begin
            errors++;
            $display("FAIL lb_signed: gnt %b rd %b mode %h done %b err %b rdata %h required 1 1 4 1 0 ffffff80",
                     o_gnt, o_rd, o_mode, o_vld, o_err, o_rdata);
        end
        data_txn(1'b0, 3'b101, 32'h42, 32'h0);
        checks++;
        if ({o_mode, o_vld, o_err, o_rdata} !== {3'b001, 1'b1, 1'b0, 32'h00008001}) begin
            errors++;
            $display("FAIL lhu: mode %h done %b err %b rdata %h required 1 1 0 00008001",
                     o_mode, o_vld, o_err, o_rdata);
        end
        data_txn(1'b0, 3'b010, 32'h41, 32'h0);
        checks++;
        if ({o_addr, o_mode, o_err, o_rdata} !== {32'h41, 3'b000, 1'b0, 32'h00800100}) begin
            errors++;
            $display("FAIL lw_misaligned: addr %h mode %h err %b rdata %h required 41 0 0 00800100",
                     o_addr, o_mode, o_err, o_rdata);
        end
        data_txn(1'b0, 3'b010, 32'hFFC, 32'h0);
        checks++;
        if ({o_rd, o_err, o_rdata} !== {1'b1, 1'b0, 32'h11223344}) begin
            errors++;
            $display("FAIL lw_last_word: rd %b err %b rdata %h required 1 0 11223344",
                     o_rd, o_err, o_rdata);
        end
    endtask

    task automatic test_store_load();
        data_txn(1'b1, 3'b001, 32'h20, 32'h1234ABCD);
        checks++;
        if ({o_rd, o_wr, o_mode, o_wdata} !== {1'b0, 1'b1, 3'b001, 32'h1234ABCD}) begin
            errors++;
            $display("FAIL sh_issue: rd %b wr %b mode %h wdata %h required 0 1 1 1234abcd",
                     o_rd, o_wr, o_mode, o_wdata);
        end
        checks++;
        if ({o_vld, o_err, o_rdata} !== {1'b1, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL sh_done: done %b err %b rdata %h required 1 0 0", o_vld, o_err, o_rdata);
        end
        data_txn(1'b0, 3'b010, 32'h20, 32'h0);
        checks++;
        if (o_rdata !== 32'h0000ABCD) begin
            errors++;
            $display("FAIL lw_after_sh: rdata %h required 0000abcd", o_rdata);
        end
    endtask

    task automatic test_errors();
        data_txn(1'b0, 3'b010, 32'hFFE, 32'h0);
        checks++;
        if ({o_rd, o_wr, o_vld, o_err, o_rdata} !== {1'b0, 1'b0, 1'b1, 1'b1, 32'd0}) begin
            errors++;
            $display("FAIL lw_range: rd %b wr %b done %b err %b rdata %h required 0 0 1 1 0",
                     o_rd, o_wr, o_vld, o_err, o_rdata);
        end
        data_txn(1'b0, 3'b011, 32'h0, 32'h0);
        checks++;
        if ({o_rd, o_vld, o_err} !== 3'b011) begin
            errors++;
            $display("FAIL load_f3_011: rd %b done %b err %b required 0 1 1", o_rd, o_vld, o_err);
        end
        data_txn(1'b1, 3'b011, 32'h30, 32'hFFFFFFFF);
        checks++;
        if ({o_wr, o_vld, o_err, mem[12'h030]} !== {1'b0, 1'b1, 1'b1, 8'hAA}) begin
            errors++;
            $display("FAIL store_f3_011: wr %b done %b err %b byte %h required 0 1 1 aa",
                     o_wr, o_vld, o_err, mem[12'h030]);
        end
        data_txn(1'b0, 3'b000, 32'hFFF, 32'h0);
        checks++;
        if ({o_rd, o_err} !== 2'b10) begin
            errors++;
            $display("FAIL lb_last_byte: rd %b err %b required 1 0", o_rd, o_err);
        end
        fetch_txn(32'h1000);
        checks++;
        if ({o_rd, o_err, o_rdata} !== {1'b0, 1'b1, 32'h00000013}) begin
            errors++;
            $display("FAIL fetch_range: rd %b rvalid %b rdata %h required 0 1 00000013",
                     o_rd, o_err, o_rdata);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_g, exp_r;
        int k;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h0;
        for (int c = 0; c < 12; c++) begin
            #1;
            k = c / 2;
            exp_g = (c % 2 == 1) ? 2'b00 : ((k % 3 == 2) ? 2'b10 : 2'b01);
            exp_r = (c % 2 == 1 || c == 0) ? 2'b00 : (((k - 1) % 3 == 2) ? 2'b10 : 2'b01);
            checks++;
            if ({if_gnt, d_gnt} !== exp_g || {if_rvalid, d_done} !== exp_r) begin
                errors++;
                $display("FAIL contention c%0d: gnt(if,d) %b resp(if,d) %b required %b %b",
                         c, {if_gnt, d_gnt}, {if_rvalid, d_done}, exp_g, exp_r);
            end
            @(negedge clk);
        end
        if_req = 1'b0; d_req = 1'b0;
        #1;
        checks++;
        if ({if_gnt, d_gnt, if_rvalid, d_done} !== 4'b0010) begin
            errors++;
            $display("FAIL contention_drain: gnt %b resp %b required 00 10",
                     {if_gnt, d_gnt}, {if_rvalid, d_done});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_store();
        logic bad_done;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b000; d_addr = 32'h30; d_wdata = 32'h55;
        #1;
        checks++;
        if (d_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rst_store_gnt: d_gnt %b required 1", d_gnt);
        end
        @(negedge clk);
        d_req = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b1) begin
            errors++;
            $display("FAIL rst_store_issue: mem_write %b required 1", mem_write);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_write, mem_addr} !== 33'd0) begin
            errors++;
            $display("FAIL rst_store_cancel: wr %b addr %h required 0 0", mem_write, mem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        bad_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            if (d_done !== 1'b0 || d_err !== 1'b0) bad_done = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad_done !== 1'b0 || mem[12'h030] !== 8'hAA) begin
            errors++;
            $display("FAIL rst_store_abandon: spurious_done %b byte %h required 0 aa",
                     bad_done, mem[12'h030]);
        end
        data_txn(1'b0, 3'b000, 32'h30, 32'h0);
        checks++;
        if (o_wait != 0 || o_rdata !== 32'hFFFFFFAA) begin
            errors++;
            $display("FAIL rst_store_idle: wait %0d rdata %h required 0 ffffffaa", o_wait, o_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_loads();
        test_store_load();
        test_errors();
        test_contention();
        test_reset_store();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
